decoder_in_sampler: RTL

- Upstream input stage for the 7-bit decoder: it feeds the decoder's 7-bit `io_in` code word.
- Synchronises raw asynchronous pad inputs, debounces the whole word, and commits a code only after it has been stable for a set number of cycles.
- Presents each committed code to the decoder over a valid/ready handshake, with sticky overrun reporting when a code is replaced before being accepted.

---
 rtl/decoder_pkg.sv | 14 +
 rtl/decoder_in_sampler_if.sv | 34 +++
 rtl/decoder_in_sampler_in_sync_chain.sv | 30 +++
 rtl/decoder_in_sampler.sv | 125 ++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// Shared constants and types for the 7-bit decoder and its input stage.
package decoder_pkg;

  localparam int DEC_WIDTH         = 7;
  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_STABLE_CYCLES = 16;

  // Settle FSM: STABLE = candidate committed or idle; SETTLE = counting matches.
  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_SETTLE = 1'b1
  } settle_state_t;

endpackage

// File: rtl/decoder_in_sampler_if.sv
// Code handshake between the input sampler (master) and the decoder (slave).
//
// Handshake: code_o is offered while code_valid_o is high and must not change
// except when a newer code is committed over it. A transfer happens on any
// rising clk edge where code_valid_o && code_ready_i. code_ready_i is ignored
// while code_valid_o is low.
interface decoder_in_sampler_if #(
  parameter int WIDTH = 7
);
  logic [WIDTH-1:0] code_o;
  logic             code_valid_o;
  logic             code_ready_i;
  logic             overrun_o;
  logic             overrun_clr_i;
  logic             busy_o;

  modport master (
    output code_o,
    output code_valid_o,
    input  code_ready_i,
    output overrun_o,
    input  overrun_clr_i,
    output busy_o
  );

  modport slave (
    input  code_o,
    input  code_valid_o,
    output code_ready_i,
    input  overrun_o,
    output overrun_clr_i,
    input  busy_o
  );
endinterface

// File: rtl/decoder_in_sampler_in_sync_chain.sv
// Per-bit multi-flop synchroniser for asynchronous pad inputs.
module in_sync_chain #(
  parameter int WIDTH       = 7,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] sync_o
);

  logic [WIDTH-1:0] stage_q [SYNC_STAGES];

  // Shift the raw word through SYNC_STAGES flops; stage 0 may go metastable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= async_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign sync_o = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/decoder_in_sampler.sv
// Input stage for the decoder: synchronise pad word, debounce it, commit a
// code after STABLE_CYCLES matching samples, and offer it over valid/ready
// with sticky overrun reporting.
module decoder_in_sampler
  import decoder_pkg::*;
#(
  parameter int WIDTH         = DEC_WIDTH,
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WIDTH-1:0]      pin_in,
  decoder_in_sampler_if.master  bus,
  output settle_state_t         dbg_state_o
);

  localparam int              CNT_W   = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0] sync_w;

  in_sync_chain #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (pin_in),
    .sync_o  (sync_w)
  );

  settle_state_t    state_q, state_d;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic [WIDTH-1:0] code_q, code_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic             busy_q, busy_d;

  logic commit_w;
  logic load_w;
  logic transfer_w;
  logic ovr_set_w;

  // State register for the settle FSM and the handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_STABLE;
      cand_q    <= '0;
      cnt_q     <= '0;
      last_q    <= '0;
      code_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      busy_q    <= busy_d;
    end
  end

  // Next-state: restart on any change, count matches, commit on the last one;
  // a commit equal to the last committed code is a returned glitch and is dropped.
  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    commit_w = 1'b0;

    if (sync_w != cand_q) begin
      cand_d  = sync_w;
      cnt_d   = '0;
      state_d = ST_SETTLE;
    end else if (state_q == ST_SETTLE) begin
      if (cnt_q == CNT_MAX) begin
        commit_w = 1'b1;
        cnt_d    = '0;
        state_d  = ST_STABLE;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    load_w     = commit_w && (cand_q != last_q);
    transfer_w = valid_q && bus.code_ready_i;
    // Overwriting a code nobody has taken; a same-cycle transfer saves it.
    ovr_set_w  = load_w && valid_q && !bus.code_ready_i;

    code_d = load_w ? cand_q : code_q;
    last_d = load_w ? cand_q : last_q;

    if (load_w) begin
      valid_d = 1'b1;
    end else if (transfer_w) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end

    if (ovr_set_w) begin
      overrun_d = 1'b1;
    end else if (bus.overrun_clr_i) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end

    busy_d = (state_d == ST_SETTLE);
  end

  assign bus.code_o       = code_q;
  assign bus.code_valid_o = valid_q;
  assign bus.overrun_o    = overrun_q;
  assign bus.busy_o       = busy_q;
  assign dbg_state_o      = state_q;

endmodule
